mod_exp_seq: RTL
================

MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 Parameter SIZEM, default 8, modulus/operand width in bits.
REQ-002 Parameter SIZEE, default 8, exponent width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin exponentiation; sampled only in IDLE.
REQ-006 base  input  SIZEM  base B, captured on accepted start.
REQ-007 exp  input  SIZEE  exponent E, captured on accepted start.
REQ-008 M  input  SIZEM  modulus, captured on accepted start.
REQ-009 result  output  SIZEM  B^E mod M; valid from done pulse until next accepted start.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  set with done when operands are illegal; cleared on next accepted start.
REQ-012 busy  output  1  high from the cycle after accepted start through the done cycle.
REQ-013 mm_start  output  1  one-cycle request to the external modular multiplier.
REQ-014 mm_T, mm_U  output  SIZEM each  multiplier operands.
REQ-015 mm_sel  output  1  0 = square (mm_T==mm_U), 1 = multiply by base.
REQ-016 mm_O  input  SIZEM+1  multiplier product, possibly in [0, 2M); valid when mm_done is high.
REQ-017 mm_done  input  1  multiplier completion pulse.

Function
REQ-018 States: IDLE, CHECK, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FIN.
REQ-019 IDLE: start=1 -> capture B, E, M; acc<=1; bit index i<=SIZEE-1; go CHECK.
REQ-020 CHECK (1 cycle): M==0 or B>=M -> err<=1, result<=0, go FIN; M==1 -> result<=0, go FIN; E==0 -> result<=1, go FIN; else go SQR_REQ.
REQ-021 SQR_REQ: mm_start=1 for exactly one cycle, mm_T=mm_U=acc, mm_sel=0; go SQR_WAIT.
REQ-022 SQR_WAIT: on mm_done, acc<=corr(mm_O); if E[i]=1 go MUL_REQ, else advance bit.
REQ-023 MUL_REQ: mm_start=1 one cycle, mm_T=acc, mm_U=B, mm_sel=1; go MUL_WAIT.
REQ-024 MUL_WAIT: on mm_done, acc<=corr(mm_O); advance bit.
REQ-025 Advance bit: i==0 -> result<=new acc, go FIN; else i<=i-1, go SQR_REQ.
REQ-026 corr(x) = x-M if x>=M, else x, computed at SIZEM+1 bits; result truncated to SIZEM bits.
REQ-027 FIN: done=1 for one cycle; go IDLE; busy deasserts the following cycle.
REQ-028 mm_T, mm_U, mm_sel are held stable from the mm_start cycle until mm_done is accepted.
REQ-029 mm_done outside SQR_WAIT/MUL_WAIT is ignored.
REQ-030 mm_done coincident with mm_start (same cycle) is ignored; a response is accepted no earlier than the cycle after mm_start.
REQ-031 start while busy is ignored; captured operands do not change during an operation.
REQ-032 start in the FIN cycle is ignored; start in the first IDLE cycle after FIN is accepted.
REQ-033 Exactly SIZEE squarings plus popcount(E) multiplies are issued for legal E!=0 (leading zeros square acc=1).
REQ-034 Latency with a multiplier responding L cycles after mm_start: 2 + (SIZEE+popcount(E))*(L+1) cycles from start to done.

Reset
REQ-035 rst=1 forces IDLE immediately: done, err, busy, mm_start, mm_sel = 0; result, mm_T, mm_U = 0; acc, i cleared.
REQ-036 rst mid-operation abandons the operation; a late mm_done after reset release is ignored (REQ-029).
REQ-037 First start is accepted on the first rising edge after rst deasserts.

Verification
REQ-038 Bench multiplier model: mm_O = (mm_T*mm_U) mod M + M when the product mod M < 256-M, else product mod M, L=3; exercises corr.
REQ-039 M=233, B=5, E=3 -> result=125, err=0, 8 squares + 2 multiplies, done at cycle 2+10*4=42.
REQ-040 M=233, B=5, E=13 -> result=48, 3 multiplies issued, mm_sel pattern checked per bit.
REQ-041 E=0, M=233 -> result=1, done 2 cycles after start, mm_start never asserted; M=1 -> result=0.
REQ-042 B=240, M=233 -> err=1, result=0, done 2 cycles after start; next legal start clears err.
REQ-043 rst pulsed during MUL_WAIT, spurious mm_done and start while busy injected -> outputs zeroed, no spurious done, following run (B=5, E=3) returns 125.

Source files
------------

// File: rtl/mod_exp_seq.sv
// Purpose : sequential left-to-right square-and-multiply modular exponentiation
//           (result = base^exp mod M) driving an external modular multiplier.
// Latency : 2 + (SIZEE + popcount(exp)) * (L + 1) cycles from start to done,
//           where L is the multiplier response time; 2 cycles for trivial operands.
// Backpressure: start is only honoured in IDLE (busy low); multiplier requests are
//           single-cycle pulses with operands held until mm_done is accepted.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, base, exp, M - request and operands (captured when start is accepted)
//   result, done, err   - answer, one-cycle completion pulse, illegal-operand flag
//   busy                - high from the cycle after an accepted start through done
//   mm_start, mm_T, mm_U, mm_sel - request to the modular multiplier (sel 0 = square)
//   mm_O, mm_done       - multiplier product in [0, 2M) and its completion pulse
module mod_exp_seq #(
    parameter int SIZEM = 8,
    parameter int SIZEE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIZEM-1:0] base,
    input  logic [SIZEE-1:0] exp,
    input  logic [SIZEM-1:0] M,
    output logic [SIZEM-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             mm_start,
    output logic [SIZEM-1:0] mm_T,
    output logic [SIZEM-1:0] mm_U,
    output logic             mm_sel,
    input  logic [SIZEM:0]   mm_O,
    input  logic             mm_done
);

    // Width of the exponent bit index; at least one bit even for SIZEE == 1.
    localparam int IW = (SIZEE > 1) ? $clog2(SIZEE) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        SQR_REQ  = 3'd2,
        SQR_WAIT = 3'd3,
        MUL_REQ  = 3'd4,
        MUL_WAIT = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [SIZEM-1:0] b_q, b_d;
    logic [SIZEE-1:0] e_q, e_d;
    logic [SIZEM-1:0] m_q, m_d;
    logic [SIZEM-1:0] acc_q, acc_d;
    logic [IW-1:0]    i_q, i_d;
    logic [SIZEM-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             mm_start_q, mm_start_d;
    logic [SIZEM-1:0] mm_t_q, mm_t_d;
    logic [SIZEM-1:0] mm_u_q, mm_u_d;
    logic             mm_sel_q, mm_sel_d;

    // Multiplier output lies in [0, 2M): one conditional subtraction brings it
    // back into [0, M). The compare is done at SIZEM+1 bits so the top bit counts.
    logic [SIZEM:0]   m_ext;
    logic [SIZEM-1:0] acc_new;

    always_comb begin
        m_ext = {1'b0, m_q};
        if (mm_O >= m_ext) begin
            acc_new = SIZEM'(mm_O - m_ext);
        end else begin
            acc_new = mm_O[SIZEM-1:0];
        end
    end

    // Helper flags: 'advance' moves to the next exponent bit (or finishes),
    // 'sqr_go' launches a squaring of sqr_src.
    logic             advance;
    logic             sqr_go;
    logic [SIZEM-1:0] sqr_src;

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        e_d        = e_q;
        m_d        = m_q;
        acc_d      = acc_q;
        i_d        = i_q;
        result_d   = result_q;
        err_d      = err_q;
        mm_start_d = 1'b0;
        mm_t_d     = mm_t_q;
        mm_u_d     = mm_u_q;
        mm_sel_d   = mm_sel_q;
        advance    = 1'b0;
        sqr_go     = 1'b0;
        sqr_src    = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exp;
                    m_d     = M;
                    acc_d   = SIZEM'(1);
                    i_d     = IW'(SIZEE - 1);
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                // Order matters: illegal operands win over the trivial cases,
                // and M == 1 wins over E == 0 (anything mod 1 is 0).
                if ((m_q == '0) || (b_q >= m_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = FIN;
                end else if (m_q == SIZEM'(1)) begin
                    result_d = '0;
                    state_d  = FIN;
                end else if (e_q == '0) begin
                    result_d = SIZEM'(1);
                    state_d  = FIN;
                end else begin
                    sqr_go  = 1'b1;
                    sqr_src = acc_q;
                end
            end

            SQR_REQ: begin
                state_d = SQR_WAIT;
            end

            SQR_WAIT: begin
                if (mm_done) begin
                    acc_d = acc_new;
                    if (e_q[i_q]) begin
                        state_d    = MUL_REQ;
                        mm_start_d = 1'b1;
                        mm_t_d     = acc_new;
                        mm_u_d     = b_q;
                        mm_sel_d   = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            MUL_REQ: begin
                state_d = MUL_WAIT;
            end

            MUL_WAIT: begin
                if (mm_done) begin
                    acc_d   = acc_new;
                    advance = 1'b1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (i_q == '0) begin
                result_d = acc_new;
                state_d  = FIN;
            end else begin
                i_d     = i_q - IW'(1);
                sqr_go  = 1'b1;
                sqr_src = acc_new;
            end
        end

        // Operands are loaded together with the request pulse and left alone
        // until the next request, so they stay stable across the wait state.
        if (sqr_go) begin
            state_d    = SQR_REQ;
            mm_start_d = 1'b1;
            mm_t_d     = sqr_src;
            mm_u_d     = sqr_src;
            mm_sel_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            b_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            mm_start_q <= 1'b0;
            mm_t_q     <= '0;
            mm_u_q     <= '0;
            mm_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            e_q        <= e_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            result_q   <= result_d;
            err_q      <= err_d;
            mm_start_q <= mm_start_d;
            mm_t_q     <= mm_t_d;
            mm_u_q     <= mm_u_d;
            mm_sel_q   <= mm_sel_d;
        end
    end

    assign result   = result_q;
    assign err      = err_q;
    assign done     = (state_q == FIN);
    assign busy     = (state_q != IDLE);
    assign mm_start = mm_start_q;
    assign mm_T     = mm_t_q;
    assign mm_U     = mm_u_q;
    assign mm_sel   = mm_sel_q;

endmodule
